// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN feature-map stream blocks.
package cnn_stream_pkg;

  localparam int DW       = 16;
  localparam int LB_DEPTH = 32;
  localparam int LB_AW    = 5;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    FILL  = 4'b0010,
    EMIT0 = 4'b0100,
    EMIT1 = 4'b1000
  } state_t;

  typedef struct packed {
    logic frame_start;
    logic line_start;
    logic frame_end;
  } markers_t;

endpackage

// File: rtl/upsample2x_if.sv
// Pixel stream in/out of the upsampler: pooled input with ready, full-rate output.
interface upsample2x_if;
  import cnn_stream_pkg::*;

  logic                 ena;
  logic signed [DW-1:0] sig_layer;
  logic                 frame_start_in;
  logic                 line_start_in;
  logic                 frame_end_in;
  logic                 in_ready;
  logic signed [DW-1:0] up_layer;
  logic                 valid;
  logic                 frame_start_out;
  logic                 line_start_out;
  logic                 frame_end_out;

  modport slave (
    input  ena, sig_layer, frame_start_in, line_start_in, frame_end_in,
    output in_ready, up_layer, valid, frame_start_out, line_start_out, frame_end_out
  );

  modport master (
    output ena, sig_layer, frame_start_in, line_start_in, frame_end_in,
    input  in_ready, up_layer, valid, frame_start_out, line_start_out, frame_end_out
  );

endinterface

// File: rtl/upsample2x_line_buf.sv
// Single-port 32-entry line buffer, active-low enable/write, 1-cycle read.
module line_buf
  import cnn_stream_pkg::*;
(
  input  logic             clk,
  input  logic             en_n,
  input  logic             wren_n,
  input  logic [LB_AW-1:0] addr,
  input  logic [DW-1:0]    data_i,
  output logic [DW-1:0]    data_o
);

  logic [DW-1:0] mem [LB_DEPTH];

  // Write on enabled write cycles, otherwise register the read word.
  always_ff @(posedge clk) begin
    if (!en_n) begin
      if (!wren_n) mem[addr] <= data_i;
      else         data_o    <= mem[addr];
    end
  end

endmodule

// File: rtl/upsample2x.sv
// Nearest-neighbour 2x upsampler: buffers one line, emits it twice with
// every pixel doubled.
module upsample2x
  import cnn_stream_pkg::*;
#(
  parameter int IN_W = 12
) (
  input logic clk,
  input logic rst,
  upsample2x_if.slave strm
);

  localparam int CW = $clog2(IN_W);
  localparam int NW = CW + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(2 * IN_W - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    col, col_nxt;
  logic [NW-1:0]    cnt, cnt_nxt;
  logic             frame_pending, pend_nxt;
  logic             last_line, last_nxt;
  logic             valid_q, valid_nxt;
  markers_t         mk_q, mk_nxt;
  logic             in_ready;
  logic             accept;
  logic             lb_en_n, lb_wren_n;
  logic [LB_AW-1:0] lb_addr;
  logic [DW-1:0]    lb_rdata;

  // Ready stays low for the cycle carrying the last output pixel, so a new
  // line is only accepted once the previous emission has fully drained.
  assign in_ready = !rst && (state == IDLE || state == FILL) && !valid_q;
  assign accept   = strm.ena && in_ready;

  line_buf u_line_buf (
    .clk    (clk),
    .en_n   (lb_en_n),
    .wren_n (lb_wren_n),
    .addr   (lb_addr),
    .data_i (strm.sig_layer),
    .data_o (lb_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, buffer access and next output markers.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    cnt_nxt   = cnt;
    pend_nxt  = frame_pending;
    last_nxt  = last_line;
    valid_nxt = 1'b0;
    mk_nxt    = '0;
    lb_en_n   = 1'b1;
    lb_wren_n = 1'b1;
    lb_addr   = '0;
    case (state)
      IDLE: begin
        if (accept && strm.frame_start_in) begin
          lb_en_n   = 1'b0;
          lb_wren_n = 1'b0;
          col_nxt   = CW'(1);
          pend_nxt  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          lb_en_n   = 1'b0;
          lb_wren_n = 1'b0;
          if (strm.frame_start_in || (strm.line_start_in && col != '0)) begin
            col_nxt = CW'(1);
            if (strm.frame_start_in) pend_nxt = 1'b1;
          end else begin
            lb_addr = LB_AW'(col);
            if (col == COL_LAST) begin
              col_nxt   = '0;
              cnt_nxt   = '0;
              last_nxt  = strm.frame_end_in;
              state_nxt = EMIT0;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
      end
      EMIT0, EMIT1: begin
        lb_en_n   = 1'b0;
        lb_addr   = LB_AW'(cnt[CW:1]);
        valid_nxt = 1'b1;
        mk_nxt.line_start = (cnt == '0);
        if (state == EMIT0 && cnt == '0 && frame_pending) begin
          mk_nxt.frame_start = 1'b1;
          pend_nxt           = 1'b0;
        end
        if (state == EMIT1 && cnt == CNT_LAST && last_line) mk_nxt.frame_end = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (state == EMIT0) begin
            state_nxt = EMIT1;
          end else begin
            col_nxt   = '0;
            state_nxt = last_line ? IDLE : FILL;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, frame flags and registered output controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      col           <= '0;
      cnt           <= '0;
      frame_pending <= 1'b0;
      last_line     <= 1'b0;
      valid_q       <= 1'b0;
      mk_q          <= '0;
    end else begin
      col           <= col_nxt;
      cnt           <= cnt_nxt;
      frame_pending <= pend_nxt;
      last_line     <= last_nxt;
      valid_q       <= valid_nxt;
      mk_q          <= mk_nxt;
    end
  end

  // The buffer's read register is the output data register; it is aligned
  // with valid_q and forced to zero whenever no pixel is being emitted.
  assign strm.in_ready        = in_ready;
  assign strm.valid           = valid_q;
  assign strm.up_layer        = valid_q ? lb_rdata : '0;
  assign strm.frame_start_out = mk_q.frame_start;
  assign strm.line_start_out  = mk_q.line_start;
  assign strm.frame_end_out   = mk_q.frame_end;

endmodule
